dline_responder: RTL and testbench

DLINE_RESPONDER -- requirements
Module: dline_responder

---
 rtl/dline_responder.sv | 157 +++++++++++++++
 tb/tb_dline_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dline_responder.sv
// dline_responder: single-line write-back data cache sitting between the
// load/store buffer and a line-wide backing memory.
// One line buffer (data, tag, valid, dirty). A miss on a dirty line writes
// it back first, then refills it. A hit responds on the next cycle.
// Optional feature: define DLINE_RESPONDER_PERF_EN to add the hit_count and
// miss_count lookup counters.
module dline_responder #(
    parameter int LINE_OFFSET_BITS = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              mem_read_d,
    input  logic                              mem_write_d,
    input  logic [3:0]                        mem_byte_enable_d,
    input  logic [31:0]                       mem_address_d,
    input  logic [31:0]                       mem_wdata_d,
    output logic                              mem_resp_d,
    output logic [31:0]                       mem_rdata_d,
    output logic                              pmem_read,
    output logic                              pmem_write,
    output logic [31:0]                       pmem_address,
    output logic [(8<<LINE_OFFSET_BITS)-1:0]  pmem_wdata,
    input  logic [(8<<LINE_OFFSET_BITS)-1:0]  pmem_rdata,
    input  logic                              pmem_resp
`ifdef DLINE_RESPONDER_PERF_EN
    ,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
`endif
);

    localparam int TAG_W  = 32 - LINE_OFFSET_BITS;
    localparam int LINE_W = 8 << LINE_OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic                  valid_q, dirty_q, aborted_q;
    logic [TAG_W-1:0]      tag_q;
    logic [LINE_W-1:0]     line_q;

    // Request latched at lookup time; the byte-offset bits never matter.
    logic [31:2]           lat_addr;
    logic [31:0]           lat_wdata;
    logic [3:0]            lat_be;
    logic                  lat_write;

    logic                  req, hit;
    logic [LINE_OFFSET_BITS-3:0] word_sel;
    logic [31:0]           cur_word, be_mask, merged_word;
    logic                  addr_lsb_unused;

    assign req             = mem_read_d | mem_write_d;
    assign hit             = valid_q && (tag_q == mem_address_d[31:LINE_OFFSET_BITS]);
    assign word_sel        = lat_addr[LINE_OFFSET_BITS-1:2];
    assign cur_word        = line_q[{word_sel, 5'd0} +: 32];
    assign be_mask         = {{8{lat_be[3]}}, {8{lat_be[2]}}, {8{lat_be[1]}}, {8{lat_be[0]}}};
    assign merged_word     = (lat_wdata & be_mask) | (cur_word & ~be_mask);
    assign addr_lsb_unused = ^mem_address_d[1:0];

    // Control state: FSM, line tag/valid/dirty, abort tracking, counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            dirty_q   <= 1'b0;
            tag_q     <= '0;
            aborted_q <= 1'b0;
`ifdef DLINE_RESPONDER_PERF_EN
            hit_count  <= '0;
            miss_count <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    aborted_q <= 1'b0;
`ifdef DLINE_RESPONDER_PERF_EN
                    if (req) begin
                        if (hit) hit_count  <= hit_count + 32'd1;
                        else     miss_count <= miss_count + 32'd1;
                    end
`endif
                end
                WB: begin
                    if (!req) aborted_q <= 1'b1;
                end
                FILL: begin
                    if (!req) aborted_q <= 1'b1;
                    if (pmem_resp) begin
                        valid_q <= 1'b1;
                        dirty_q <= 1'b0;
                        tag_q   <= lat_addr[31:LINE_OFFSET_BITS];
                    end
                end
                RESP: begin
                    if (lat_write && (|lat_be)) dirty_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: request latch at lookup, line refill and store merge.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req) begin
            lat_addr  <= mem_address_d[31:2];
            lat_wdata <= mem_wdata_d;
            lat_be    <= mem_byte_enable_d;
            lat_write <= mem_write_d;
        end
        if (state_q == FILL && pmem_resp) begin
            line_q <= pmem_rdata;
        end else if (state_q == RESP && lat_write) begin
            line_q[{word_sel, 5'd0} +: 32] <= merged_word;
        end
    end

    // Next state and all block outputs; everything idles at zero.
    always_comb begin
        state_d      = state_q;
        mem_resp_d   = 1'b0;
        mem_rdata_d  = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit)                  state_d = RESP;
                    else if (valid_q && dirty_q) state_d = WB;
                    else                      state_d = FILL;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q, {LINE_OFFSET_BITS{1'b0}}};
                pmem_wdata   = line_q;
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {lat_addr[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                // An abandoned request still installs the line but gets no response.
                if (pmem_resp) state_d = (req && !aborted_q) ? RESP : IDLE;
            end
            RESP: begin
                mem_resp_d = 1'b1;
                if (!lat_write) mem_rdata_d = cur_word;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dline_responder.sv
// Directed bench for dline_responder: refill, hit timing, store merge,
// dirty write-back, zero-enable store, reset mid-refill and abandoned refill.
module tb_dline_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read_d, mem_write_d;
    logic [3:0]   mem_byte_enable_d;
    logic [31:0]  mem_address_d, mem_wdata_d;
    logic         mem_resp_d;
    logic [31:0]  mem_rdata_d;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
`ifdef DLINE_RESPONDER_PERF_EN
    logic [31:0]  hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [255:0] line1, line1_merged, line2, line3;

    dline_responder dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_d        (mem_read_d),
        .mem_write_d       (mem_write_d),
        .mem_byte_enable_d (mem_byte_enable_d),
        .mem_address_d     (mem_address_d),
        .mem_wdata_d       (mem_wdata_d),
        .mem_resp_d        (mem_resp_d),
        .mem_rdata_d       (mem_rdata_d),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
`ifdef DLINE_RESPONDER_PERF_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        mem_read_d        = rd;
        mem_write_d       = wr;
        mem_address_d     = addr;
        mem_byte_enable_d = be;
        mem_wdata_d       = wd;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line1[32*i +: 32] = 32'h1000_0000 + i;
            line2[32*i +: 32] = 32'h2000_0000 + i;
            line3[32*i +: 32] = 32'h3000_0000 + i;
        end
        line1[63:32]   = 32'hDEAD_BEEF;
        line1[127:96]  = 32'hAAAA_AAAA;
        line1_merged   = line1;
        line1_merged[127:96] = 32'hAAAA_5678;
        line2[31:0]    = 32'hCAFE_F00D;

        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        step();
        step();
        chk("rst_resp",  mem_resp_d,   1'b0);
        chk("rst_rdata", mem_rdata_d,  32'h0);
        chk("rst_pread", pmem_read,    1'b0);
        chk("rst_pwrite", pmem_write,  1'b0);
        chk("rst_paddr", pmem_address, 32'h0);
        chk("rst_pwdata", pmem_wdata,  256'h0);
        rst = 1'b0;

        // Cold miss refill
        drive(1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
        step();
        chk("fill_pread", pmem_read,    1'b1);
        chk("fill_paddr", pmem_address, 32'h0000_1000);
        chk("fill_pwrite", pmem_write,  1'b0);
        chk("fill_noresp", mem_resp_d,  1'b0);
        step();
        chk("fill_hold", pmem_read, 1'b1);
        pmem_rdata = line1;
        pmem_resp  = 1'b1;
        step();
        pmem_resp  = 1'b0;
        chk("fill_resp",  mem_resp_d,  1'b1);
        chk("fill_rdata", mem_rdata_d, 32'hDEAD_BEEF);
        chk("fill_pread_off", pmem_read, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("fill_pulse_end", mem_resp_d, 1'b0);
        chk("rdata_zero", mem_rdata_d, 32'h0);

        // Hit with request held through the return to IDLE
        drive(1'b1, 1'b0, 32'h0000_1008, 4'h0, 32'h0);
        #1;
        chk("hit_not_same_cycle", mem_resp_d, 1'b0);
        step();
        chk("hit_resp",  mem_resp_d,  1'b1);
        chk("hit_rdata", mem_rdata_d, 32'h1000_0002);
        chk("hit_no_pread", pmem_read,  1'b0);
        chk("hit_no_pwrite", pmem_write, 1'b0);
        step();
        chk("hit_gap_cycle", mem_resp_d, 1'b0);
        step();
        chk("hit_resample", mem_resp_d, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Partial store then read back
        drive(1'b0, 1'b1, 32'h0000_100C, 4'b0011, 32'h1234_5678);
        step();
        chk("wr_resp", mem_resp_d, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0000_100C, 4'h0, 32'h0);
        step();
        chk("wr_readback", mem_rdata_d, 32'hAAAA_5678);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Dirty eviction: write-back then refill
        drive(1'b1, 1'b0, 32'h0000_2000, 4'h0, 32'h0);
        step();
        chk("wb_pwrite", pmem_write,   1'b1);
        chk("wb_pread",  pmem_read,    1'b0);
        chk("wb_paddr",  pmem_address, 32'h0000_1000);
        chk("wb_pwdata", pmem_wdata,   line1_merged);
        step();
        chk("wb_hold", pmem_write, 1'b1);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        chk("wb_fill_pread",  pmem_read,    1'b1);
        chk("wb_fill_pwrite", pmem_write,   1'b0);
        chk("wb_fill_paddr",  pmem_address, 32'h0000_2000);
        pmem_rdata = line2;
        pmem_resp  = 1'b1;
        step();
        pmem_resp  = 1'b0;
        chk("wb_resp",  mem_resp_d,  1'b1);
        chk("wb_rdata", mem_rdata_d, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        // Store with no byte enables leaves the line clean
        drive(1'b0, 1'b1, 32'h0000_2004, 4'b0000, 32'hFFFF_FFFF);
        step();
        chk("be0_resp", mem_resp_d, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0000_3000, 4'h0, 32'h0);
        step();
        chk("be0_clean_pwrite", pmem_write, 1'b0);
        chk("be0_clean_pread",  pmem_read,  1'b1);

        // Reset in the middle of a refill
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        chk("rst_mid_pread", pmem_read,    1'b0);
        chk("rst_mid_paddr", pmem_address, 32'h0);
        step();
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0);
        step();
        chk("post_rst_miss", pmem_read,    1'b1);
        chk("post_rst_paddr", pmem_address, 32'h0000_2000);

        // Abandoned refill still installs the line
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        chk("abort_fill_hold", pmem_read, 1'b1);
        pmem_rdata = line3;
        pmem_resp  = 1'b1;
        step();
        pmem_resp  = 1'b0;
        chk("abort_noresp", mem_resp_d, 1'b0);
        chk("abort_pread_off", pmem_read, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0);
        step();
        chk("abort_rehit_resp",  mem_resp_d,  1'b1);
        chk("abort_rehit_rdata", mem_rdata_d, 32'h3000_0001);
        chk("abort_rehit_nopmem", pmem_read, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
